// File: rtl/prco_mem_arbiter_if.sv
// Request/ack and RAM signal bundle for the PRCO memory arbiter.
// The master modport is the arbiter's view; slave is the requesters' and RAM's view.
interface prco_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              q_if_ack;
  logic [DATA_W-1:0] q_if_data;

  logic              i_ls_req;
  logic              i_ls_we;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic              q_ls_ack;
  logic [DATA_W-1:0] q_ls_rdata;

  logic              q_mem_en;
  logic              q_mem_we;
  logic [ADDR_W-1:0] q_mem_addr;
  logic [DATA_W-1:0] q_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              q_p_block;

  modport master (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_mem_rdata,
    output q_if_ack, q_if_data, q_ls_ack, q_ls_rdata,
    output q_mem_en, q_mem_we, q_mem_addr, q_mem_wdata, q_p_block
  );

  modport slave (
    output i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_mem_rdata,
    input  q_if_ack, q_if_data, q_ls_ack, q_ls_rdata,
    input  q_mem_en, q_mem_we, q_mem_addr, q_mem_wdata, q_p_block
  );
endinterface

// File: rtl/prco_mem_arbiter.sv
// Shares the single-port PRCO RAM between instruction fetch (IF) and load/store (LS).
// One access at a time: IDLE -> ACCESS (MEM_LAT+1 cycles) -> DONE (ack) -> IDLE.
module prco_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input logic                i_clk,
  input logic                i_reset,
  prco_mem_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_ls_q, last_ls_d;
  logic              grant_ls_q, grant_ls_d;
  logic              acc_we_q, acc_we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              pick_ls;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_ls_d   = last_ls_q;
    grant_ls_d  = grant_ls_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_data_d   = if_data_q;
    ls_rdata_d  = ls_rdata_q;
    // On a tie the requester that was not granted last wins.
    pick_ls     = bus.i_ls_req & (~bus.i_if_req | ~last_ls_q);

    unique case (state_q)
      StIdle: begin
        if (bus.i_if_req || bus.i_ls_req) begin
          grant_ls_d = pick_ls;
          last_ls_d  = pick_ls;
          acc_we_d   = pick_ls & bus.i_ls_we;
          mem_en_d   = 1'b1;
          mem_we_d   = pick_ls & bus.i_ls_we;
          mem_addr_d = pick_ls ? bus.i_ls_addr : bus.i_if_addr;
          if (pick_ls) begin
            mem_wdata_d = bus.i_ls_wdata;
          end
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == CntLast) begin
          state_d = StDone;
          if (grant_ls_q) begin
            ls_ack_d = 1'b1;
            if (!acc_we_q) begin
              ls_rdata_d = bus.i_mem_rdata;
            end
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = bus.i_mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      // Ack cycle; no grant here so a request dropped with its ack is never re-served.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_ls_q   <= 1'b0;
      grant_ls_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_ls_q   <= last_ls_d;
      grant_ls_q  <= grant_ls_d;
      acc_we_q    <= acc_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_data_q   <= if_data_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.q_if_ack    = if_ack_q;
  assign bus.q_if_data   = if_data_q;
  assign bus.q_ls_ack    = ls_ack_q;
  assign bus.q_ls_rdata  = ls_rdata_q;
  assign bus.q_mem_en    = mem_en_q;
  assign bus.q_mem_we    = mem_we_q;
  assign bus.q_mem_addr  = mem_addr_q;
  assign bus.q_mem_wdata = mem_wdata_q;
  assign bus.q_p_block   = bus.i_ls_req & ~ls_ack_q;

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// Directed bench for prco_mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances sharing a RAM model.
module tb_prco_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prco_mem_arbiter_if b1 ();
  prco_mem_arbiter_if b3 ();

  prco_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b1.master)
  );

  prco_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b3.master)
  );

  // RAM model: dut1 sees data 1 cycle after enable, dut3 sees it 3 cycles after.
  logic [15:0] ram [0:1023];
  logic [15:0] p3  [0:2];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (b1.q_mem_en && b1.q_mem_we) ram[b1.q_mem_addr[9:0]] <= b1.q_mem_wdata;
    b1.i_mem_rdata <= b1.q_mem_en ? ram[b1.q_mem_addr[9:0]] : 16'hDEAD;
    p3[0] <= b3.q_mem_en ? ram[b3.q_mem_addr[9:0]] : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.i_mem_rdata = p3[2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  int          cyc, nack, en_cnt, ack_at, nack_rst;
  int          ack_cyc [3];
  logic        ack_ls  [3];
  logic [15:0] ack_dat [3];
  int          exp_cyc [3] = '{3, 7, 11};
  logic        exp_ls  [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] exp_dat [3] = '{16'h2222, 16'hA5C3, 16'h3333};
  logic [15:0] got_dat;

  initial begin
    rst = 1'b1;
    b1.i_if_req = 0; b1.i_if_addr = '0; b1.i_ls_req = 0; b1.i_ls_we = 0;
    b1.i_ls_addr = '0; b1.i_ls_wdata = '0;
    b3.i_if_req = 0; b3.i_if_addr = '0; b3.i_ls_req = 0; b3.i_ls_we = 0;
    b3.i_ls_addr = '0; b3.i_ls_wdata = '0;
    preload(10'h010, 16'hA5C3);
    preload(10'h030, 16'h1111);
    preload(10'h040, 16'h2222);
    preload(10'h041, 16'h3333);
    preload(10'h100, 16'hBEEF);
    step(2);
    rst = 1'b0;

    // Reset state
    check_eq("rst_if_ack", b1.q_if_ack, 0);
    check_eq("rst_ls_ack", b1.q_ls_ack, 0);
    check_eq("rst_mem_en", b1.q_mem_en, 0);
    check_eq("rst_mem_we", b1.q_mem_we, 0);
    check_eq("rst_mem_addr", b1.q_mem_addr, 0);
    check_eq("rst_mem_wdata", b1.q_mem_wdata, 0);
    check_eq("rst_if_data", b1.q_if_data, 0);
    check_eq("rst_ls_rdata", b1.q_ls_rdata, 0);
    check_eq("rst_p_block", b1.q_p_block, 0);

    // Fetch only
    b1.i_if_addr = 16'h0010; b1.i_if_req = 1;
    step();
    check_eq("f_c1_en", b1.q_mem_en, 1);
    check_eq("f_c1_addr", b1.q_mem_addr, 16'h0010);
    check_eq("f_c1_we", b1.q_mem_we, 0);
    check_eq("f_c1_ack", b1.q_if_ack, 0);
    step();
    check_eq("f_c2_en", b1.q_mem_en, 0);
    check_eq("f_c2_ack", b1.q_if_ack, 0);
    check_eq("f_c2_addr_hold", b1.q_mem_addr, 16'h0010);
    step();
    check_eq("f_c3_ack", b1.q_if_ack, 1);
    check_eq("f_c3_data", b1.q_if_data, 16'hA5C3);
    check_eq("f_c3_ls_ack", b1.q_ls_ack, 0);
    b1.i_if_req = 0;
    step();
    check_eq("f_c4_ack", b1.q_if_ack, 0);
    check_eq("f_c4_data_hold", b1.q_if_data, 16'hA5C3);

    // Store then load of the same address
    b1.i_ls_we = 1; b1.i_ls_addr = 16'h0020; b1.i_ls_wdata = 16'h1234; b1.i_ls_req = 1;
    #1;
    check_eq("st_c0_pblk", b1.q_p_block, 1);
    step();
    check_eq("st_c1_en", b1.q_mem_en, 1);
    check_eq("st_c1_we", b1.q_mem_we, 1);
    check_eq("st_c1_addr", b1.q_mem_addr, 16'h0020);
    check_eq("st_c1_wdata", b1.q_mem_wdata, 16'h1234);
    check_eq("st_c1_pblk", b1.q_p_block, 1);
    step();
    check_eq("st_c2_we", b1.q_mem_we, 0);
    check_eq("st_c2_en", b1.q_mem_en, 0);
    check_eq("st_c2_pblk", b1.q_p_block, 1);
    step();
    check_eq("st_c3_ack", b1.q_ls_ack, 1);
    check_eq("st_c3_pblk", b1.q_p_block, 0);
    check_eq("st_c3_rdata_kept", b1.q_ls_rdata, 0);
    b1.i_ls_we = 0;
    step();
    check_eq("ld_c4_ack", b1.q_ls_ack, 0);
    check_eq("ld_c4_pblk", b1.q_p_block, 1);
    step();
    check_eq("ld_c5_en", b1.q_mem_en, 1);
    check_eq("ld_c5_we", b1.q_mem_we, 0);
    step(2);
    check_eq("ld_c7_ack", b1.q_ls_ack, 1);
    check_eq("ld_c7_rdata", b1.q_ls_rdata, 16'h1234);
    b1.i_ls_req = 0;
    step();

    // Simultaneous requests right after reset: LS first
    rst = 1'b1; step(); rst = 1'b0;
    b1.i_if_addr = 16'h0030; b1.i_if_req = 1;
    b1.i_ls_addr = 16'h0040; b1.i_ls_we = 0; b1.i_ls_req = 1;
    step();
    check_eq("tie_c1_addr", b1.q_mem_addr, 16'h0040);
    step(2);
    check_eq("tie_c3_ls_ack", b1.q_ls_ack, 1);
    check_eq("tie_c3_if_ack", b1.q_if_ack, 0);
    check_eq("tie_c3_rdata", b1.q_ls_rdata, 16'h2222);
    b1.i_ls_req = 0;
    step();
    check_eq("tie_c4_ls_ack", b1.q_ls_ack, 0);
    step();
    check_eq("tie_c5_en", b1.q_mem_en, 1);
    check_eq("tie_c5_addr", b1.q_mem_addr, 16'h0030);
    step(2);
    check_eq("tie_c7_if_ack", b1.q_if_ack, 1);
    check_eq("tie_c7_if_data", b1.q_if_data, 16'h1111);
    b1.i_if_req = 0;
    step();

    // Continuous LS with IF pending: LS, IF, LS
    b1.i_ls_addr = 16'h0040; b1.i_ls_req = 1;
    b1.i_if_addr = 16'h0010; b1.i_if_req = 1;
    cyc = 0; nack = 0;
    for (int i = 0; i < 3; i++) begin
      ack_cyc[i] = 0; ack_ls[i] = 1'bx; ack_dat[i] = 'x;
    end
    while (nack < 3 && cyc < 40) begin
      step(); cyc++;
      if (b1.q_ls_ack) begin
        ack_cyc[nack] = cyc; ack_ls[nack] = 1'b1; ack_dat[nack] = b1.q_ls_rdata;
        nack++;
        b1.i_ls_addr = 16'h0041;
      end else if (b1.q_if_ack) begin
        ack_cyc[nack] = cyc; ack_ls[nack] = 1'b0; ack_dat[nack] = b1.q_if_data;
        nack++;
        b1.i_if_req = 0;
      end
    end
    b1.i_ls_req = 0;
    b1.i_if_req = 0;
    check_eq("alt_nack", nack, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("alt%0d_cyc", i), ack_cyc[i], exp_cyc[i]);
      check_eq($sformatf("alt%0d_is_ls", i), {31'd0, ack_ls[i]}, {31'd0, exp_ls[i]});
      check_eq($sformatf("alt%0d_data", i), ack_dat[i], exp_dat[i]);
    end
    step();

    // Reset during ACCESS
    b1.i_if_addr = 16'h0010; b1.i_if_req = 1;
    step();
    check_eq("rma_c1_en", b1.q_mem_en, 1);
    rst = 1'b1; b1.i_if_req = 0;
    step();
    check_eq("rma_en", b1.q_mem_en, 0);
    check_eq("rma_addr", b1.q_mem_addr, 0);
    check_eq("rma_if_ack", b1.q_if_ack, 0);
    check_eq("rma_if_data", b1.q_if_data, 0);
    check_eq("rma_ls_rdata", b1.q_ls_rdata, 0);
    rst = 1'b0;
    nack_rst = 0;
    repeat (4) begin
      step();
      if (b1.q_if_ack || b1.q_ls_ack) nack_rst++;
    end
    check_eq("rma_no_ack", nack_rst, 0);
    b1.i_if_addr = 16'h0030; b1.i_if_req = 1;
    step();
    check_eq("rma_new_en", b1.q_mem_en, 1);
    step(2);
    check_eq("rma_new_ack", b1.q_if_ack, 1);
    check_eq("rma_new_data", b1.q_if_data, 16'h1111);
    b1.i_if_req = 0;
    step();

    // MEM_LAT=3 load
    b3.i_ls_addr = 16'h0100; b3.i_ls_we = 0; b3.i_ls_req = 1;
    en_cnt = 0; ack_at = -1; got_dat = 'x;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (b3.q_mem_en) en_cnt++;
      if (c == 1) check_eq("l3_c1_en", b3.q_mem_en, 1);
      if (b3.q_ls_ack) begin
        if (ack_at < 0) begin
          ack_at = c; got_dat = b3.q_ls_rdata;
        end
        b3.i_ls_req = 0;
      end
    end
    check_eq("l3_en_count", en_cnt, 1);
    check_eq("l3_ack_cycle", ack_at, 5);
    check_eq("l3_rdata", got_dat, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
